// File: rtl/sbox_roundtrip_bist.sv
// sbox_roundtrip_bist: sweeps 0x00..0xFF through an external S-box round trip
// and checks each returned byte against the one sent, keeping a pass/fail summary.
module sbox_roundtrip_bist #(
    parameter int LATENCY = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       stim_valid,
    output logic [7:0] stim_data,
    input  logic [7:0] resp_data,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [8:0] err_count,
    output logic [7:0] first_err_in,
    output logic [7:0] first_err_out
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    state_t r_state, w_next;
    logic         r_stim_valid, r_busy, r_done, r_pass;
    logic [7:0]   r_stim_data, r_first_in, r_first_out;
    logic [8:0]   r_err;
    logic [4:0]   r_drain;
    logic [LATENCY-1:0] r_sh_v;
    logic [7:0]   r_sh_d [LATENCY];
    logic         w_accept, w_last_stim, w_drain_end, w_mismatch;
    assign w_accept    = start && (r_state == IDLE || r_state == DONE);
    assign w_last_stim = r_state == RUN && r_stim_data == 8'hFF;
    assign w_drain_end = r_state == DRAIN && r_drain == 5'(LATENCY - 1);
    assign w_mismatch  = r_sh_v[LATENCY-1] && resp_data != r_sh_d[LATENCY-1];
    always_ff @(posedge clk or posedge rst)
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    always_comb begin
        w_next = r_state;
        w_next = w_accept ? RUN : w_last_stim ? DRAIN : w_drain_end ? DONE : r_state;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stim_valid <= 1'b0;
            r_stim_data  <= 8'h00;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_err        <= 9'd0;
            r_first_in   <= 8'h00;
            r_first_out  <= 8'h00;
            r_drain      <= 5'd0;
            r_sh_v       <= '0;
            for (int k = 0; k < LATENCY; k++) r_sh_d[k] <= 8'h00;
        end else begin
            r_stim_valid <= w_next == RUN;
            r_stim_data  <= w_accept ? 8'h00 : r_stim_valid ? r_stim_data + 8'd1 : r_stim_data;
            r_busy       <= w_next == RUN || w_next == DRAIN;
            r_drain      <= r_state == DRAIN ? r_drain + 5'd1 : 5'd0;
            // An accepted start flushes in-flight expectations so stale bytes never compare.
            r_sh_v[0]    <= r_stim_valid && !w_accept;
            r_sh_d[0]    <= r_stim_data;
            for (int k = 1; k < LATENCY; k++) begin
                r_sh_v[k] <= r_sh_v[k-1] && !w_accept;
                r_sh_d[k] <= r_sh_d[k-1];
            end
            if (w_accept) begin
                r_err       <= 9'd0;
                r_first_in  <= 8'h00;
                r_first_out <= 8'h00;
                r_done      <= 1'b0;
                r_pass      <= 1'b0;
            end else begin
                if (w_mismatch) begin
                    r_err <= r_err + 9'd1;
                    if (r_err == 9'd0) begin
                        r_first_in  <= r_sh_d[LATENCY-1];
                        r_first_out <= resp_data;
                    end
                end
                // The final compare lands on the same edge as done, so fold it into pass.
                if (w_drain_end) begin
                    r_done <= 1'b1;
                    r_pass <= r_err == 9'd0 && !w_mismatch;
                end
            end
        end
    end
    assign stim_valid    = r_stim_valid;
    assign stim_data     = r_stim_data;
    assign busy          = r_busy;
    assign done          = r_done;
    assign pass          = r_pass;
    assign err_count     = r_err;
    assign first_err_in  = r_first_in;
    assign first_err_out = r_first_out;
endmodule

// File: tb/tb_sbox_roundtrip_bist.sv
// tb_sbox_roundtrip_bist: directed sweeps through loopback, AES S-box chain,
// single-fault and stuck-at responses, plus start/reset control cases.
module tb_sbox_roundtrip_bist;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       stim_valid, busy, done, pass;
    logic [7:0] stim_data, resp_data, first_err_in, first_err_out;
    logic [8:0] err_count;
    int         n_cmp = 0, n_bad = 0;
    int         mode = 0;
    logic [7:0] sb [256];
    logic [7:0] isb [256];
    logic [7:0] d0, d1, d2, d3, f0, f1, g0, g1, i0, i1, mid_53;
    int         done_k, nvalid, first_v, last_v, nbusy;
    logic       order_ok, k1_done;
    logic [8:0] k1_err;

    sbox_roundtrip_bist #(.LATENCY(4)) dut (
        .clk(clk), .rst(rst), .start(start),
        .stim_valid(stim_valid), .stim_data(stim_data), .resp_data(resp_data),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .first_err_in(first_err_in), .first_err_out(first_err_out)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] ginv(input logic [7:0] a);
        if (a == 8'h00) return 8'h00;
        for (int c = 1; c < 256; c++) if (gmul(a, 8'(c)) == 8'h01) return 8'(c);
        return 8'h00;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
        return 8'((x << n) | (x >> (8 - n)));
    endfunction

    // Loopback delay line and a 2+2 cycle forward/inverse S-box chain.
    always @(posedge clk) begin
        d0 <= stim_data; d1 <= d0; d2 <= d1; d3 <= d2;
        f0 <= sb[stim_data]; g0 <= stim_data;
        f1 <= f0; g1 <= g0;
        i0 <= isb[f1]; i1 <= i0;
        if (mode == 1 && g1 == 8'h53) mid_53 <= f1;
    end

    always_comb
        resp_data = mode == 0 ? d3 : mode == 1 ? i1 : mode == 2 ? (d3 == 8'h53 ? 8'h00 : d3) : 8'h00;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_sweep(input int rp1, input int rp2);
        done_k = 0; nvalid = 0; first_v = 0; last_v = 0; nbusy = 0; order_ok = 1'b1;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int k = 1; k <= 400; k++) begin
            if (k == 1) begin k1_done = done; k1_err = err_count; end
            if (stim_valid) begin
                if (first_v == 0) first_v = k;
                last_v = k;
                if (stim_data != 8'(nvalid)) order_ok = 1'b0;
                nvalid++;
            end
            if (busy) nbusy++;
            if (done) begin done_k = k; break; end
            start = (k == rp1 || k == rp2);
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    initial begin
        for (int v = 0; v < 256; v++) begin
            logic [7:0] b, s;
            b = ginv(8'(v));
            s = b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
            sb[v] = s;
            isb[s] = 8'(v);
        end
        repeat (3) @(negedge clk);
        check("rst_stim_valid", 32'(stim_valid), 0);
        check("rst_stim_data", 32'(stim_data), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_pass", 32'(pass), 0);
        check("rst_err_count", 32'(err_count), 0);
        check("rst_first_in", 32'(first_err_in), 0);
        check("rst_first_out", 32'(first_err_out), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        mode = 0;
        run_sweep(0, 0);
        check("loop_done_cycle", done_k, 261);
        check("loop_valid_count", nvalid, 256);
        check("loop_first_valid", first_v, 1);
        check("loop_last_valid", last_v, 256);
        check("loop_byte_order", 32'(order_ok), 1);
        check("loop_busy_cycles", nbusy, 260);
        check("loop_pass", 32'(pass), 1);
        check("loop_err_count", 32'(err_count), 0);
        check("loop_first_in", 32'(first_err_in), 0);
        check("loop_first_out", 32'(first_err_out), 0);

        mode = 1; mid_53 = 8'h00;
        run_sweep(0, 0);
        check("chain_done_cycle", done_k, 261);
        check("chain_pass", 32'(pass), 1);
        check("chain_err_count", 32'(err_count), 0);
        check("chain_mid_53", 32'(mid_53), 32'hED);

        mode = 2;
        run_sweep(100, 258);
        check("fault_done_cycle", done_k, 261);
        check("fault_busy_cycles", nbusy, 260);
        check("fault_done", 32'(done), 1);
        check("fault_pass", 32'(pass), 0);
        check("fault_err_count", 32'(err_count), 1);
        check("fault_first_in", 32'(first_err_in), 32'h53);
        check("fault_first_out", 32'(first_err_out), 0);

        mode = 3;
        run_sweep(0, 0);
        check("stuck_pass", 32'(pass), 0);
        check("stuck_err_count", 32'(err_count), 255);
        check("stuck_first_in", 32'(first_err_in), 32'h01);
        check("stuck_first_out", 32'(first_err_out), 0);

        mode = 0;
        run_sweep(0, 0);
        check("redo_k1_done", 32'(k1_done), 0);
        check("redo_k1_err", 32'(k1_err), 0);
        check("redo_first_valid", first_v, 1);
        check("redo_done_cycle", done_k, 261);
        check("redo_pass", 32'(pass), 1);

        mode = 3;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (99) @(negedge clk);
        check("mid_err_count", 32'(err_count), 94);
        check("mid_stim_data", 32'(stim_data), 99);
        rst = 1'b1;
        #1;
        check("abort_stim_valid", 32'(stim_valid), 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_err_count", 32'(err_count), 0);
        check("abort_first_in", 32'(first_err_in), 0);
        check("abort_stim_data", 32'(stim_data), 0);
        repeat (2) @(negedge clk);
        check("abort_hold_valid", 32'(stim_valid), 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("post_rst_idle_busy", 32'(busy), 0);
        check("post_rst_idle_valid", 32'(stim_valid), 0);

        mode = 0;
        run_sweep(0, 0);
        check("after_rst_done_cycle", done_k, 261);
        check("after_rst_pass", 32'(pass), 1);
        check("after_rst_err_count", 32'(err_count), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
